vx_local_mem_pipelined: RTL and testbench
=========================================

Name: vx_local_mem_pipelined

Overview:
- Parametrised, synthesizable local memory model; sits on the Vortex mem_req/mem_rsp bus in place of the fixed single-cycle local RAM.
- Adds configurable read latency, a credit-limited response queue with real backpressure, optional write acknowledgements, an address window (base and depth), and sticky out-of-bounds capture.

Parameters:
- DATA_WIDTH, 512, bus data width; byte-enable width is DATA_WIDTH/8.
- ADDR_WIDTH, 26, word (line) address width.
- TAG_WIDTH, 56, request/response tag width.
- NUM_WORDS, 4096, physical depth in lines.
- BASE_ADDR, 0, first line address mapped to word 0.
- LATENCY, 2, cycles from request accept to earliest mem_rsp_valid; must be 1 or more.
- RSP_FIFO_DEPTH, 4, response queue depth and maximum outstanding responses; must be 2 or more.
- WRITE_ACK, 0, when 1 every write returns a response with data=0.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- mem_req_valid  in  1  request valid
- mem_req_rw  in  1  1=write, 0=read
- mem_req_byteen  in  DATA_WIDTH/8  write byte enables
- mem_req_addr  in  ADDR_WIDTH  line address
- mem_req_data  in  DATA_WIDTH  write data
- mem_req_tag  in  TAG_WIDTH  request tag
- mem_req_ready  out  1  request accepted when valid&&ready
- mem_rsp_valid  out  1  response valid
- mem_rsp_data  out  DATA_WIDTH  read data
- mem_rsp_tag  out  TAG_WIDTH  tag of the request being answered
- mem_rsp_ready  in  1  consumer ready
- busy  out  1  any response outstanding
- oob_err  out  1  sticky out-of-bounds flag
- oob_addr  out  ADDR_WIDTH  first offending address

Behaviour:
- Reset (reset=0, async): mem_req_ready=0, mem_rsp_valid=0, mem_rsp_data=0, mem_rsp_tag=0, busy=0, oob_err=0, oob_addr=0. Credit counter 0, pipeline valids cleared, FIFO emptied. Memory array contents are not reset. Reset mid-operation discards all in-flight responses. mem_req_ready rises on the first clk edge after release.
- Credits: a credit is a response-generating request (every read; a write when WRITE_ACK=1).
  - Counter increments on accept of such a request and decrements on response pop.
  - When both happen in the same cycle, the counter is unchanged.
  - mem_req_ready = (credits < RSP_FIFO_DEPTH), registered-free combinational from the counter. The FIFO can never overflow.
  - A write with WRITE_ACK=0 consumes no credit, but is still gated by mem_req_ready for simplicity.
- Address decode: offset = addr - BASE_ADDR, unsigned ADDR_WIDTH arithmetic. In range iff addr >= BASE_ADDR and offset < NUM_WORDS.
- Write (in range): bytes with byteen[i]=1 update on the accept edge; other bytes are kept.
- Read: array sampled on the accept edge. Ordering is strict in accept order: a read sees every write accepted in an earlier cycle.
- Out of range:
  - Write is dropped; read returns all-zero data.
  - In both cases oob_err is set. On the first set, oob_addr latches addr; later violations do not overwrite it. Both clear only on reset.
  - The response is still produced and the tag is preserved.
- Pipeline: LATENCY-1 register stages of {valid, tag, data} after the sample stage, then the FIFO.
  - Accept in cycle N gives mem_rsp_valid in cycle N+LATENCY when the FIFO is empty and ready.
  - Responses return strictly in request order.
- Response port: mem_rsp_valid = FIFO not empty. Head data/tag are stable while valid && !ready. Pop on valid&&ready.
- Write-ack response: data = 0, tag = request tag.
- busy = (credits != 0).
- Back-to-back: one accept per cycle sustained when mem_rsp_ready=1 and RSP_FIFO_DEPTH >= LATENCY+1.

Decomposition:
- Package vx_local_mem_pkg: rsp_entry_t {tag, data} struct, localparam BYTEEN_WIDTH, and function in_range(addr) for the address check.
- Sub-module vx_lmem_rsp_fifo: synchronous FIFO (DEPTH, entry type), ptr/count, async active-low reset.
- Top level holds the array, pipeline, credit counter and OOB logic.

Test Plan (DATA_WIDTH=512, LATENCY=2, RSP_FIFO_DEPTH=4, BASE_ADDR=0x100, NUM_WORDS=16 unless noted):
- Write addr 0x105 with byteen=all-ones, data=pattern A, tag 0x1; then read 0x105 with tag 0x2 -> rsp data=A, tag=0x2, mem_rsp_valid exactly 2 cycles after the read accept; no write response when WRITE_ACK=0.
- Partial write 0x106: first all-ones with data=0xFF..., then byteen=0x1 with data=0x00 -> read returns 0xFF...FF00 (byte 0 cleared only).
- Hold mem_rsp_ready=0 and issue 6 reads -> exactly 4 accepted, mem_req_ready=0 from the 5th, busy=1; release ready -> 4 responses return in order, then the 5th accepts.
- Read 0x0FF then 0x110 -> both return data 0, tags preserved, oob_err=1, oob_addr=0x0FF (not 0x110).
- WRITE_ACK=1: write 0x100 with tag 0x7 -> response data=0, tag=0x7 at accept+2, credit consumed and released.
- Assert reset with 3 reads in flight -> mem_rsp_valid=0 and busy=0 immediately; a post-reset read of a previously written address returns the retained data.

Source files
------------

// File: rtl/vx_local_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package     : vx_local_mem_pkg
// Description : Shared types and the address-window check for the local memory.
// Revision    : 1.0 - initial release
// ============================================================================
package vx_local_mem_pkg;

    localparam int LMEM_DATA_WIDTH = 512;
    localparam int LMEM_TAG_WIDTH  = 56;
    localparam int BYTEEN_WIDTH    = LMEM_DATA_WIDTH / 8;

    typedef struct packed {
        logic [LMEM_TAG_WIDTH-1:0]  tag;
        logic [LMEM_DATA_WIDTH-1:0] data;
    } rsp_entry_t;

    // Operands are zero-extended to 64 bits; addr >= base rules out wrap, so this
    // matches the ADDR_WIDTH-bit offset comparison.
    function automatic logic in_range(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input logic [63:0] num_words);
        return (addr >= base) && ((addr - base) < num_words);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vx_lmem_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vx_lmem_rsp_fifo
// Description : Synchronous response FIFO; head reads as zero while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module vx_lmem_rsp_fifo
    import vx_local_mem_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type ENTRY_T = rsp_entry_t
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  ENTRY_T push_entry,
    input  logic   pop,
    output ENTRY_T head,
    output logic   empty
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    ENTRY_T             r_store [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_pop;

    assign empty = (r_count == '0);
    assign w_pop = pop && !empty;
    assign head  = empty ? '0 : r_store[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            r_store[r_wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= (r_wr_ptr == c_ptr_w'(DEPTH - 1)) ? '0 : r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_w'(DEPTH - 1)) ? '0 : r_rd_ptr + c_ptr_w'(1);
            end
            if (push && !w_pop) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (!push && w_pop) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vx_local_mem_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : vx_local_mem_pipelined
// Description : Vortex local memory with configurable read latency, a credit-
//               limited response queue, optional write acks and sticky OOB capture.
// Revision    : 1.0 - initial release
// ============================================================================
module vx_local_mem_pipelined
    import vx_local_mem_pkg::*;
#(
    parameter int          DATA_WIDTH     = 512,
    parameter int          ADDR_WIDTH     = 26,
    parameter int          TAG_WIDTH      = 56,
    parameter int          NUM_WORDS      = 4096,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int          LATENCY        = 2,
    parameter int          RSP_FIFO_DEPTH = 4,
    parameter int          WRITE_ACK      = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_req_valid,
    input  logic                    mem_req_rw,
    input  logic [DATA_WIDTH/8-1:0] mem_req_byteen,
    input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
    input  logic [DATA_WIDTH-1:0]   mem_req_data,
    input  logic [TAG_WIDTH-1:0]    mem_req_tag,
    output logic                    mem_req_ready,
    output logic                    mem_rsp_valid,
    output logic [DATA_WIDTH-1:0]   mem_rsp_data,
    output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
    input  logic                    mem_rsp_ready,
    output logic                    busy,
    output logic                    oob_err,
    output logic [ADDR_WIDTH-1:0]   oob_addr
);

    localparam int c_be_w     = DATA_WIDTH / 8;
    localparam int c_idx_w    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int c_cred_w   = $clog2(RSP_FIFO_DEPTH + 1);
    localparam int c_stages   = LATENCY - 1;

    typedef struct packed {
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [DATA_WIDTH-1:0] r_mem [NUM_WORDS];
    logic                  r_ready_en;
    logic [c_cred_w-1:0]   r_credits;
    logic                  r_oob_err;
    logic [ADDR_WIDTH-1:0] r_oob_addr;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_gen;
    logic                  w_pop;
    logic                  w_in_range;
    logic [c_idx_w-1:0]    w_index;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_fifo_push;
    logic                  w_fifo_empty;
    entry_t                w_req_entry;
    entry_t                w_fifo_push_entry;
    entry_t                w_head;

    assign w_in_range = in_range(64'(mem_req_addr), 64'(BASE_ADDR), 64'(NUM_WORDS));
    assign w_index    = c_idx_w'(mem_req_addr - ADDR_WIDTH'(BASE_ADDR));

    // r_ready_en holds ready low until the first edge after reset release.
    assign w_ready  = r_ready_en && (r_credits < c_cred_w'(RSP_FIFO_DEPTH));
    assign w_accept = mem_req_valid && w_ready;
    assign w_gen    = w_accept && (!mem_req_rw || (WRITE_ACK != 0));
    assign w_pop    = mem_rsp_valid && mem_rsp_ready;

    // Write-ack and out-of-range responses both carry zero data.
    assign w_rd_data   = (w_in_range && !mem_req_rw) ? r_mem[w_index] : '0;
    assign w_req_entry = '{tag: mem_req_tag, data: w_rd_data};

    always_ff @(posedge clk) begin
        if (w_accept && mem_req_rw && w_in_range) begin
            for (int b = 0; b < c_be_w; b++) begin
                if (mem_req_byteen[b]) begin
                    r_mem[w_index][b*8 +: 8] <= mem_req_data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ready_en <= 1'b0;
            r_credits  <= '0;
            r_oob_err  <= 1'b0;
            r_oob_addr <= '0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_gen && !w_pop) begin
                r_credits <= r_credits + c_cred_w'(1);
            end else if (!w_gen && w_pop) begin
                r_credits <= r_credits - c_cred_w'(1);
            end
            if (w_accept && !w_in_range) begin
                r_oob_err <= 1'b1;
                if (!r_oob_err) begin
                    r_oob_addr <= mem_req_addr;
                end
            end
        end
    end

    // The FIFO write is the final latency stage, so only LATENCY-1 registers sit before it.
    generate
        if (LATENCY > 1) begin : g_pipe
            logic   r_vld [c_stages];
            entry_t r_ent [c_stages];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int s = 0; s < c_stages; s++) begin
                        r_vld[s] <= 1'b0;
                        r_ent[s] <= '0;
                    end
                end else begin
                    r_vld[0] <= w_gen;
                    r_ent[0] <= w_req_entry;
                    for (int s = 1; s < c_stages; s++) begin
                        r_vld[s] <= r_vld[s-1];
                        r_ent[s] <= r_ent[s-1];
                    end
                end
            end

            assign w_fifo_push       = r_vld[c_stages-1];
            assign w_fifo_push_entry = r_ent[c_stages-1];
        end else begin : g_direct
            assign w_fifo_push       = w_gen;
            assign w_fifo_push_entry = w_req_entry;
        end
    endgenerate

    vx_lmem_rsp_fifo #(
        .DEPTH   (RSP_FIFO_DEPTH),
        .ENTRY_T (entry_t)
    ) u_rsp_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (w_fifo_push),
        .push_entry (w_fifo_push_entry),
        .pop        (w_pop),
        .head       (w_head),
        .empty      (w_fifo_empty)
    );

    assign mem_req_ready = w_ready;
    assign mem_rsp_valid = !w_fifo_empty;
    assign mem_rsp_data  = w_head.data;
    assign mem_rsp_tag   = w_head.tag;
    assign busy          = (r_credits != '0);
    assign oob_err       = r_oob_err;
    assign oob_addr      = r_oob_addr;

endmodule
`default_nettype wire

// File: tb/tb_vx_local_mem_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : tb_vx_local_mem_pipelined
// Description : Randomized self-checking bench against a queue-based memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vx_local_mem_pipelined;

    localparam int          DW    = 512;
    localparam int          AW    = 26;
    localparam int          TW    = 56;
    localparam int          BW    = DW / 8;
    localparam int unsigned BASE  = 32'h100;
    localparam int          NW    = 16;
    localparam int          DEPTH = 4;
    localparam int          LAT   = 2;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    int            cyc   = 0;

    logic          req_valid = 1'b0;
    logic          req_rw    = 1'b0;
    logic [BW-1:0] req_be    = '0;
    logic [AW-1:0] req_addr  = '0;
    logic [DW-1:0] req_data  = '0;
    logic [TW-1:0] req_tag   = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic [TW-1:0] rsp_tag;
    logic          busy;
    logic          oob_err;
    logic [AW-1:0] oob_addr;
    logic          dir_rdy  = 1'b1;
    logic          rnd_mode = 1'b0;
    logic          rnd_rdy  = 1'b1;
    wire           rsp_ready = rnd_mode ? rnd_rdy : dir_rdy;

    logic          a_valid = 1'b0;
    logic          a_rw    = 1'b0;
    logic [BW-1:0] a_be    = '0;
    logic [AW-1:0] a_addr  = '0;
    logic [DW-1:0] a_data  = '0;
    logic [TW-1:0] a_tag   = '0;
    logic          a_rsp_rdy = 1'b1;
    logic          a_ready;
    logic          a_rsp_valid;
    logic [DW-1:0] a_rsp_data;
    logic [TW-1:0] a_rsp_tag;
    logic          a_busy;
    logic          a_oob_err;
    logic [AW-1:0] a_oob_addr;

    vx_local_mem_pipelined #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .NUM_WORDS(NW),
        .BASE_ADDR(BASE), .LATENCY(LAT), .RSP_FIFO_DEPTH(DEPTH), .WRITE_ACK(0)
    ) dut (
        .clk(clk), .reset(reset),
        .mem_req_valid(req_valid), .mem_req_rw(req_rw), .mem_req_byteen(req_be),
        .mem_req_addr(req_addr), .mem_req_data(req_data), .mem_req_tag(req_tag),
        .mem_req_ready(req_ready),
        .mem_rsp_valid(rsp_valid), .mem_rsp_data(rsp_data), .mem_rsp_tag(rsp_tag),
        .mem_rsp_ready(rsp_ready),
        .busy(busy), .oob_err(oob_err), .oob_addr(oob_addr)
    );

    vx_local_mem_pipelined #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .NUM_WORDS(NW),
        .BASE_ADDR(BASE), .LATENCY(LAT), .RSP_FIFO_DEPTH(DEPTH), .WRITE_ACK(1)
    ) dut_ack (
        .clk(clk), .reset(reset),
        .mem_req_valid(a_valid), .mem_req_rw(a_rw), .mem_req_byteen(a_be),
        .mem_req_addr(a_addr), .mem_req_data(a_data), .mem_req_tag(a_tag),
        .mem_req_ready(a_ready),
        .mem_rsp_valid(a_rsp_valid), .mem_rsp_data(a_rsp_data), .mem_rsp_tag(a_rsp_tag),
        .mem_rsp_ready(a_rsp_rdy),
        .busy(a_busy), .oob_err(a_oob_err), .oob_addr(a_oob_addr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rnd_rdy <= ($urandom_range(0, 3) != 0);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [575:0] got, input logic [575:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: line store, in-order expected responses, sticky OOB state.
    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
        int            acc;
    } exp_t;

    logic [DW-1:0] mm [NW];
    exp_t          q[$];
    int            last_pop   = -1;
    logic          m_oob      = 1'b0;
    logic [AW-1:0] m_oob_addr = '0;
    logic          chk_en     = 1'b0;

    function automatic logic [DW-1:0] rnd512();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic void model_accept();
        int unsigned a;
        logic        inr;
        int          idx;
        exp_t        e;
        a   = int'(req_addr);
        inr = (a >= BASE) && (a < BASE + NW);
        idx = inr ? int'(a - BASE) : 0;
        if (!inr && !m_oob) begin
            m_oob      = 1'b1;
            m_oob_addr = req_addr;
        end
        if (req_rw) begin
            if (inr) begin
                for (int b = 0; b < BW; b++) begin
                    if (req_be[b]) mm[idx][8*b +: 8] = req_data[8*b +: 8];
                end
            end
        end else begin
            e.tag  = req_tag;
            e.data = inr ? mm[idx] : '0;
            e.acc  = cyc;
            q.push_back(e);
        end
    endfunction

    // Response i is visible from max(accept_i + LAT, previous pop + 1).
    always @(negedge clk) begin
        if (chk_en) begin
            bit ev;
            ev = (q.size() > 0) && (cyc >= q[0].acc + LAT) && (cyc > last_pop);
            check("req_ready", req_ready, q.size() < DEPTH);
            check("busy", busy, q.size() != 0);
            check("rsp_valid", rsp_valid, ev);
            check("oob_err", oob_err, m_oob);
            check("oob_addr", oob_addr, m_oob_addr);
            if (ev) begin
                check("rsp_data", rsp_data, q[0].data);
                check("rsp_tag", rsp_tag, q[0].tag);
                if (rsp_ready) begin
                    void'(q.pop_front());
                    last_pop = cyc;
                end
            end
            if (req_valid && req_ready) model_accept();
        end
    end

    task automatic req(input logic rw, input logic [AW-1:0] addr, input logic [BW-1:0] be,
                       input logic [DW-1:0] data, input logic [TW-1:0] tag);
        bit done = 1'b0;
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_be    = be;
        req_data  = data;
        req_tag   = tag;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            done = req_ready;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        check("req_accept", done, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", q.size() == 0, 1'b1);
    endtask

    task automatic reset_assert();
        reset  = 1'b0;
        chk_en = 1'b0;
        q.delete();
        last_pop   = -1;
        m_oob      = 1'b0;
        m_oob_addr = '0;
        #1;
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, '0);
        check("rst_rsp_tag", rsp_tag, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_oob_err", oob_err, 1'b0);
        check("rst_oob_addr", oob_addr, '0);
        check("rst_ack_busy", a_busy, 1'b0);
    endtask

    task automatic reset_release();
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("ready_low_after_release", req_ready, 1'b0);
        @(posedge clk);
        #1 chk_en = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1);
    end

    logic [DW-1:0] pat;
    logic [AW-1:0] raddr;
    logic          rrw;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset_assert();
        reset_release();

        for (int i = 0; i < NW; i++) req(1'b1, AW'(BASE + i), '1, rnd512(), TW'(i));

        // Full write then read-back; no response for the write.
        pat = rnd512();
        req(1'b1, AW'('h105), '1, pat, TW'('h1));
        req(1'b0, AW'('h105), '0, '0, TW'('h2));
        drain();

        // Partial write clears byte 0 only.
        req(1'b1, AW'('h106), '1, '1, TW'('h3));
        req(1'b1, AW'('h106), BW'(1), '0, TW'('h4));
        req(1'b0, AW'('h106), '0, '0, TW'('h5));
        drain();

        // Credit limit: four reads fill the queue, the fifth waits for drain.
        dir_rdy = 1'b0;
        for (int i = 0; i < 4; i++) req(1'b0, AW'(BASE + i), '0, '0, TW'(16 + i));
        fork
            begin
                repeat (5) @(posedge clk);
                #1 dir_rdy = 1'b1;
            end
        join_none
        req(1'b0, AW'(BASE + 4), '0, '0, TW'(20));
        req(1'b0, AW'(BASE + 5), '0, '0, TW'(21));
        drain();

        // Out-of-window reads on both sides; first offender is kept.
        req(1'b0, AW'('h0FF), '0, '0, TW'('h30));
        req(1'b0, AW'('h110), '0, '0, TW'('h31));
        drain();
        check("oob_err_dir", oob_err, 1'b1);
        check("oob_addr_dir", oob_addr, AW'('h0FF));

        rnd_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            raddr = AW'($urandom_range(BASE - 8, BASE + NW + 7));
            rrw   = 1'($urandom_range(0, 1));
            req(rrw, raddr, {$urandom, $urandom}, rnd512(), TW'({$urandom, $urandom}));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rnd_mode = 1'b0;
        drain();

        // Write acknowledge on the second instance.
        a_valid = 1'b1;
        a_rw    = 1'b1;
        a_addr  = AW'('h100);
        a_be    = '1;
        a_data  = rnd512();
        a_tag   = TW'('h7);
        @(negedge clk);
        check("ack_idle_busy", a_busy, 1'b0);
        check("ack_req_ready", a_ready, 1'b1);
        @(posedge clk);
        #1 a_valid = 1'b0;
        @(negedge clk);
        check("ack_busy", a_busy, 1'b1);
        check("ack_valid_early", a_rsp_valid, 1'b0);
        @(negedge clk);
        check("ack_valid", a_rsp_valid, 1'b1);
        check("ack_data", a_rsp_data, '0);
        check("ack_tag", a_rsp_tag, TW'('h7));
        check("ack_busy_held", a_busy, 1'b1);
        @(negedge clk);
        check("ack_valid_after", a_rsp_valid, 1'b0);
        check("ack_busy_after", a_busy, 1'b0);
        @(posedge clk);
        #1;

        // Reset with reads in flight; the array keeps its contents.
        dir_rdy = 1'b0;
        req(1'b0, AW'(BASE + 5), '0, '0, TW'('h40));
        req(1'b0, AW'(BASE + 6), '0, '0, TW'('h41));
        req(1'b0, AW'(BASE + 7), '0, '0, TW'('h42));
        reset_assert();
        dir_rdy = 1'b1;
        repeat (2) @(posedge clk);
        reset_release();
        req(1'b0, AW'(BASE + 5), '0, '0, TW'('h50));
        req(1'b0, AW'('h106), '0, '0, TW'('h51));
        drain();
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
